stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control FSM and seconds counter for the lab stopwatch. It turns the start/pause and clear button pulses plus a 1 Hz tick into a two-digit BCD elapsed-seconds count. It also produces the `min` (≥ MIN_S seconds) and `timeout` (limit reached) levels consumed by the LED indicator block, and the digit values consumed by the display driver. It sits between the debounced button/prescaler logic and the LED/display blocks.

## Interface
- `LIMIT_S`, 99: timeout threshold in seconds; legal range 1..99.
- `MIN_S`, 60: threshold for `min`; legal range 1..99, and must be ≤ LIMIT_S.

- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: one-cycle pulse, once per second, from the prescaler.
- `btn_start` input 1: one-cycle pulse (already debounced); toggles run/pause.
- `btn_clear` input 1: one-cycle pulse (already debounced); returns to zero/idle.
- `sec_ones` output 4: BCD units digit of elapsed seconds (0..9).
- `sec_tens` output 4: BCD tens digit of elapsed seconds (0..9).
- `running` output 1: high while in RUN.
- `min` output 1: high while the count is ≥ MIN_S.
- `timeout` output 1: high while in DONE.

## Operation
- The FSM has four states: IDLE, RUN, PAUSE, DONE. It uses a 2-bit state register with a binary encoding.
- **IDLE**: count = 00.
  - `btn_start` → RUN.
  - `tick` is ignored.
- **RUN**: on `tick`, the count increments by 1 in BCD.
  - `sec_ones` 9 wraps to 0, and `sec_tens` increments at the same time.
  - If the incremented count equals LIMIT_S, the next state is DONE (the same edge that loads the count).
  - `btn_start` → PAUSE.
- **PAUSE**: the count is held and `tick` is ignored.
  - `btn_start` → RUN.
- **DONE**: the count is held at LIMIT_S.
  - `btn_start` and `tick` are ignored.
- **Clear and reset**:
  - `btn_clear` in any state → IDLE with the count set to 00.
  - `rst` has the same effect and overrides all other inputs.
- **Priority within one cycle**: `rst` > `btn_clear` > (`tick`, `btn_start`).
- **RUN with `tick` and `btn_start` in the same cycle**:
  - The tick is counted, and the next state is PAUSE.
  - If that tick reaches LIMIT_S, the next state is DONE instead (the limit wins over pause).
- **Limit comparison**: LIMIT_S and MIN_S are compared in BCD form (tens = P/10, ones = P%10), computed at elaboration. No binary counter is kept.
- **Output decoding**:
  - `min` is a decode of the registered digits: (tens, ones) ≥ (MIN_S/10, MIN_S%10).
  - `running` = (state == RUN).
  - `timeout` = (state == DONE).
- **Glitch-free outputs**: all outputs are functions of registers only. No input reaches any output combinationally.

## Timing
- **Reset**: the cycle after `rst` is sampled high, the outputs are:
  - state IDLE;
  - `sec_ones` = 0, `sec_tens` = 0;
  - `running` = 0, `min` = 0, `timeout` = 0.
- **Latency**: one cycle from any input pulse to the corresponding output change.
  - `btn_start` sampled at edge k → `running` changes after edge k.
  - `tick` sampled at edge k → the digits change after edge k.
- **`min`**: rises on the same edge the count reaches MIN_S.
- **`timeout`**: rises on the same edge the count reaches LIMIT_S. From that point it stays high until clear or reset.
- **Pulse widths**: inputs are one-cycle pulses. A pulse held longer than one cycle is acted on every cycle it is high; for `btn_start` this means repeated toggling. The block does no edge detection.
- **No counting during PAUSE**: ticks arriving in PAUSE are lost, not deferred.

## Test plan
- **Reset**:
  - Stimulus: hold `rst` = 1 for 2 cycles while `btn_start` = 1 and `tick` = 1.
  - Required: digits 0/0, `running` = `min` = `timeout` = 0.
  - Then, after `rst` is released with no stimulus, all outputs stay at these values.
- **Count and wrap**:
  - Stimulus: `btn_start`, then 10 `tick`s.
  - Required: after tick 9, `sec_ones` = 9 / `sec_tens` = 0. After tick 10, `sec_ones` = 0 / `sec_tens` = 1. `running` = 1 throughout.
- **min and timeout** (defaults):
  - Stimulus: `btn_start`, then 99 `tick`s.
  - Required: `min` rises on tick 60. `timeout` rises on tick 99 with digits 9/9 and `running` = 0. Further ticks and `btn_start` leave 9/9 and DONE unchanged.
- **Pause**:
  - Stimulus: in RUN at count 05, pulse `btn_start`, then 3 `tick`s, then `btn_start` again and 1 `tick`.
  - Required: the count stays 05 during PAUSE with `running` = 0. It is 06 after the final tick.
- **Simultaneous events**:
  - Stimulus 1: in RUN at 07, apply `tick` + `btn_start` in one cycle.
    - Required: count 08, PAUSE.
  - Stimulus 2: with LIMIT_S = 10 at 09, apply `tick` + `btn_start` in one cycle.
    - Required: count 10, DONE, `timeout` = 1.
- **Clear priority**:
  - Stimulus: in DONE (and separately in RUN at 42), apply `btn_clear` + `tick` + `btn_start` in one cycle.
  - Required: IDLE, count 00, `min` = 0, `timeout` = 0, `running` = 0.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button/tick pulses into the stopwatch and the digit/indicator levels out of it.
// Inputs are single-cycle pulses acted on every cycle they are high; outputs are
// levels valid every cycle, so there is no valid/ready and no backpressure.
interface stopwatch_ctrl_if;
    logic       tick;
    logic       btn_start;
    logic       btn_clear;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic       running;
    logic       min;
    logic       timeout;
    logic [1:0] dbg_state;

    modport master (
        output tick, btn_start, btn_clear,
        input  sec_ones, sec_tens, running, min, timeout, dbg_state
    );

    modport slave (
        input  tick, btn_start, btn_clear,
        output sec_ones, sec_tens, running, min, timeout, dbg_state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with a two-digit BCD seconds counter; all outputs are
// decoded from registers only.
module stopwatch_ctrl #(
    parameter int LIMIT_S = 99,
    parameter int MIN_S   = 60
) (
    input logic             clk,
    input logic             rst,
    stopwatch_ctrl_if.slave sw
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Thresholds split into BCD digits at elaboration; no binary count exists.
    localparam logic [3:0] LIM_T = 4'(LIMIT_S / 10);
    localparam logic [3:0] LIM_O = 4'(LIMIT_S % 10);
    localparam logic [3:0] MIN_T = 4'(MIN_S / 10);
    localparam logic [3:0] MIN_O = 4'(MIN_S % 10);

    state_t     state;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] inc_ones;
    logic [3:0] inc_tens;
    logic       inc_at_limit;

    always_comb begin
        inc_ones     = 4'd0;
        inc_tens     = tens;
        inc_at_limit = 1'b0;
        if (ones == 4'd9) begin
            inc_ones = 4'd0;
            inc_tens = tens + 4'd1;
        end else begin
            inc_ones = ones + 4'd1;
        end
        inc_at_limit = (inc_tens == LIM_T) && (inc_ones == LIM_O);
    end

    always_ff @(posedge clk) begin
        if (rst || sw.btn_clear) begin
            state <= S_IDLE;
            ones  <= 4'd0;
            tens  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sw.btn_start) state <= S_RUN;
                end
                S_RUN: begin
                    // A tick that reaches the limit beats a same-cycle pause.
                    if (sw.tick) begin
                        ones <= inc_ones;
                        tens <= inc_tens;
                        if (inc_at_limit)      state <= S_DONE;
                        else if (sw.btn_start) state <= S_PAUSE;
                    end else if (sw.btn_start) begin
                        state <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (sw.btn_start) state <= S_RUN;
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign sw.sec_ones  = ones;
    assign sw.sec_tens  = tens;
    assign sw.running   = (state == S_RUN);
    assign sw.timeout   = (state == S_DONE);
    assign sw.min       = (tens > MIN_T) || ((tens == MIN_T) && (ones >= MIN_O));
    assign sw.dbg_state = state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench: two stopwatch instances (default and LIMIT_S=10/MIN_S=5)
// driven with identical stimulus and checked against an integer-seconds model.
module tb_stopwatch_ctrl;
  localparam int W = 22;
  localparam int LIM_B = 10;
  localparam int MIN_B = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk;
  logic rst;
  stopwatch_ctrl_if sw_a ();
  stopwatch_ctrl_if sw_b ();

  stopwatch_ctrl dut_a (
    .clk(clk),
    .rst(rst),
    .sw (sw_a.slave)
  );

  stopwatch_ctrl #(.LIMIT_S(LIM_B), .MIN_S(MIN_B)) dut_b (
    .clk(clk),
    .rst(rst),
    .sw (sw_b.slave)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  logic [10:0]  got_a;
  logic [10:0]  got_b;
  int n_compared;
  int n_mismatched;
  int secs_a, mode_a, secs_b, mode_b;
  int cycle;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
    sw_a.tick = 1'b0; sw_a.btn_start = 1'b0; sw_a.btn_clear = 1'b0;
    sw_b.tick = 1'b0; sw_b.btn_start = 1'b0; sw_b.btn_clear = 1'b0;
  end

  // reference model: elapsed seconds as a plain integer
  task automatic model_step(input int lim, input logic r, s, c, t,
                            inout int secs, inout int mode);
    if (r || c) begin
      secs = 0;
      mode = M_IDLE;
    end else begin
      case (mode)
        M_IDLE:  if (s) mode = M_RUN;
        M_RUN: begin
          if (t) secs = secs + 1;
          if (t && secs == lim) mode = M_DONE;
          else if (s) mode = M_PAUSE;
        end
        M_PAUSE: if (s) mode = M_RUN;
        default: mode = M_DONE;
      endcase
    end
  endtask

  function automatic logic [10:0] model_out(input int secs, input int mode, input int mn);
    logic [3:0] t4;
    logic [3:0] o4;
    t4 = 4'(secs / 10);
    o4 = 4'(secs % 10);
    return {t4, o4, (mode == M_RUN), (secs >= mn), (mode == M_DONE)};
  endfunction

  // driver: apply inputs for one edge, then push what the outputs must be after it
  task automatic step(input logic r, s, c, t);
    rst = r;
    sw_a.btn_start = s; sw_a.btn_clear = c; sw_a.tick = t;
    sw_b.btn_start = s; sw_b.btn_clear = c; sw_b.tick = t;
    @(posedge clk);
    model_step(99, r, s, c, t, secs_a, mode_a);
    model_step(LIM_B, r, s, c, t, secs_b, mode_b);
    exp_q.push_back({model_out(secs_a, mode_a, 60), model_out(secs_b, mode_b, MIN_B)});
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic restart;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // monitor: outputs are valid every cycle, one expected entry per edge
  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      got_a = {sw_a.sec_tens, sw_a.sec_ones, sw_a.running, sw_a.min, sw_a.timeout};
      got_b = {sw_b.sec_tens, sw_b.sec_ones, sw_b.running, sw_b.min, sw_b.timeout};
      n_compared = n_compared + 2;
      if (got_a !== exp_w[21:11]) begin
        n_mismatched = n_mismatched + 1;
        $display("FAIL dut_a cycle %0d: got tens/ones/run/min/tmo %h/%h/%b/%b/%b required %h/%h/%b/%b/%b",
                 cycle, got_a[10:7], got_a[6:3], got_a[2], got_a[1], got_a[0],
                 exp_w[21:18], exp_w[17:14], exp_w[13], exp_w[12], exp_w[11]);
      end
      if (got_b !== exp_w[10:0]) begin
        n_mismatched = n_mismatched + 1;
        $display("FAIL dut_b cycle %0d: got tens/ones/run/min/tmo %h/%h/%b/%b/%b required %h/%h/%b/%b/%b",
                 cycle, got_b[10:7], got_b[6:3], got_b[2], got_b[1], got_b[0],
                 exp_w[10:7], exp_w[6:3], exp_w[2], exp_w[1], exp_w[0]);
      end
    end
  end

  initial begin
    logic r, s, c, t;
    n_compared = 0;
    n_mismatched = 0;
    cycle = 0;
    secs_a = 0; mode_a = M_IDLE; secs_b = 0; mode_b = M_IDLE;

    // reset held against start and tick, then quiet cycles
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    // count and wrap past 09
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);

    // full run to the limit, then ignored ticks and starts in DONE
    restart();
    ticks(99);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    // clear in DONE with everything else asserted
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // pause at 05: ticks lost, then resume
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);

    // tick + start at 07 -> 08 and paused
    restart();
    ticks(7);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    ticks(2);

    // tick + start at 09 -> dut_b reaches its limit of 10 instead of pausing
    restart();
    ticks(9);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    ticks(2);

    // clear beats tick + start while running at 42
    restart();
    ticks(42);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // held start pulse toggles every cycle
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 24) == 0);
      t = ($urandom_range(0, 2) == 0);
      step(r, s, c, t);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_mismatched = n_mismatched + 1;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("final debug states: dut_a %0d dut_b %0d", sw_a.dbg_state, sw_b.dbg_state);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
